shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, DATA_WIDTH, unsigned multiplicand.
REQ-007 SHALL have port b, input, DATA_WIDTH, unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1, product present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the product.
REQ-010 SHALL have port product, output, 2*DATA_WIDTH, unsigned a*b.
REQ-011 SHALL have port busy, output, 1, high while in state RUN.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, out_valid = 1 only in DONE, and busy = 1 only in RUN.
REQ-014 SHALL accept an operand pair on an edge where in_valid && in_ready: capture a and b, clear the partial-product register, load the iteration counter with DATA_WIDTH, and go to RUN.
REQ-015 SHALL ignore a and b at all times other than the accept edge.
REQ-016 SHALL, on each RUN edge, do the following:
- if the current multiplier LSB = 1, add the multiplicand to the upper DATA_WIDTH bits of the partial product as a DATA_WIDTH-bit add with carry-in 0;
- otherwise add 0;
- shift {carry-out, upper sum, lower half} right by one bit;
- decrement the counter.
REQ-017 SHALL perform exactly DATA_WIDTH RUN iterations regardless of operand values, with no early exit on zero operands.
REQ-018 SHALL, on the RUN edge where the counter reaches 0, load the product output register with the final 2*DATA_WIDTH-bit result and enter DONE.
REQ-019 SHALL assert out_valid exactly DATA_WIDTH cycles after the accept edge.
REQ-020 SHALL keep product and out_valid stable in DONE until out_valid && out_ready; on that edge it SHALL return to IDLE.
REQ-021 SHALL NOT accept a new operand pair on the same edge as the output transfer; the minimum issue interval is DATA_WIDTH+2 cycles.
REQ-022 SHALL hold product at the last delivered result in IDLE and RUN; product is meaningful only while out_valid = 1.
REQ-023 SHALL never lose the carry-out of the add, so the result is exact for every operand pair, including all-ones operands.
REQ-024 SHALL honour rst on any edge, in any state including mid-RUN: the operation in progress is discarded, with no partial result and no out_valid.

Reset
REQ-025 SHALL, on an edge with rst = 1, enter IDLE and clear all of the following: product, partial product, counter and operand registers.
REQ-026 SHALL present the following outputs in the cycle after that reset edge: in_ready = 1, out_valid = 0, busy = 0, product = 0.
REQ-027 SHALL give rst priority over in_valid and out_ready on the same edge.

Verification (DATA_WIDTH = 4)
REQ-028 SHALL cover: a = 4'b1010, b = 4'b0110 accepted, out_ready = 1 -> out_valid rises 4 cycles after accept with product = 8'h3C; in_ready is 1 the cycle after the transfer.
REQ-029 SHALL cover: a = 4'hF, b = 4'hF -> product = 8'hE1 (carry-out path exercised).
REQ-030 SHALL cover: a = 0, b = 4'hD -> product = 8'h00, still exactly 4 cycles of busy = 1.
REQ-031 SHALL cover: a = 3, b = 5 with out_ready held 0 for 3 cycles in DONE and in_valid = 1 with other operands -> the following hold until out_ready = 1:
- product stays 8'h0F;
- out_valid stays 1;
- in_ready stays 0;
- no new operand pair is accepted.
REQ-032 SHALL cover: rst = 1 on the 2nd RUN cycle of 7*9 -> next cycle IDLE, out_valid = 0, product = 0; a following 3*5 yields 8'h0F.
REQ-033 SHALL cover: a and b changed every cycle during RUN of 12*11 -> product = 8'h84, unaffected.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-add step per cycle over DATA_WIDTH cycles,
// with valid/ready handshakes on the operand input and the product output.
module shift_add_mult #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [DATA_WIDTH-1:0]     a_r;
  logic [DATA_WIDTH-1:0]     b_r;
  logic [2*DATA_WIDTH-1:0]   pp_r;
  logic [2*DATA_WIDTH-1:0]   pp_nxt_s;
  logic [2*DATA_WIDTH-1:0]   product_r;
  logic [CW-1:0]             cnt_r;
  logic [DATA_WIDTH-1:0]     addend_s;
  logic [DATA_WIDTH:0]       sum_s;
  logic                      last_s;

  // One shift-add step; the carry-out is kept as the new MSB so the result stays exact
  always_comb begin
    addend_s = {DATA_WIDTH{1'b0}};
    if (b_r[0]) begin
      addend_s = a_r;
    end else begin
      addend_s = {DATA_WIDTH{1'b0}};
    end
    sum_s    = {1'b0, pp_r[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend_s};
    pp_nxt_s = {sum_s, pp_r[DATA_WIDTH-1:1]};
    last_s   = (cnt_r == CNT_ONE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE never falls through to an accept on the transfer edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and product register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {DATA_WIDTH{1'b0}};
      b_r       <= {DATA_WIDTH{1'b0}};
      pp_r      <= {(2*DATA_WIDTH){1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2*DATA_WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            pp_r  <= {(2*DATA_WIDTH){1'b0}};
            cnt_r <= CNT_LOAD;
          end
        end
        RUN: begin
          pp_r  <= pp_nxt_s;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r - CNT_ONE;
          if (last_s) begin
            product_r <= pp_nxt_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign out_valid = (state_r == DONE);
  assign product   = product_r;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult (DATA_WIDTH = 4): table of operand/product vectors
// plus hand-written reset and mid-run reset sequences.
module tb_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    int         stall;
    bit         scramble;
  } vec_t;

  vec_t vecs [6];

  shift_add_mult #(.DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency/busy cycles, optionally stall and scramble inputs
  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp,
                        input int stall, input bit scramble);
    int lat;
    int busy_cnt;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("idle_before_issue", {31'd0, in_ready}, 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      step();
      lat++;
    end
    chk("latency", lat, 32'd4);
    chk("busy_cycles", busy_cnt, 32'd4);
    chk("product", {24'd0, product}, {24'd0, exp});
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = ~va;
      b = ~vb;
      step();
      chk("stall_product", {24'd0, product}, {24'd0, exp});
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("post_xfer_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_xfer_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_xfer_busy", {31'd0, busy}, 32'd0);
    chk("post_xfer_product_held", {24'd0, product}, {24'd0, exp});
  endtask

  initial begin
    vecs[0] = '{a: 4'hA, b: 4'h6, exp: 8'h3C, stall: 0, scramble: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'hF, exp: 8'hE1, stall: 0, scramble: 1'b0};
    vecs[2] = '{a: 4'h0, b: 4'hD, exp: 8'h00, stall: 0, scramble: 1'b0};
    vecs[3] = '{a: 4'h3, b: 4'h5, exp: 8'h0F, stall: 3, scramble: 1'b0};
    vecs[4] = '{a: 4'hC, b: 4'hB, exp: 8'h84, stall: 0, scramble: 1'b1};
    vecs[5] = '{a: 4'h8, b: 4'h8, exp: 8'h40, stall: 1, scramble: 1'b0};

    // Reset with in_valid and out_ready high: reset must win
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 4'hF;
    b = 4'hF;
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_product", {24'd0, product}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].scramble);
    end

    // Establish a nonzero delivered product, then reset on the 2nd RUN cycle of 7*9
    run_op(4'hF, 4'hF, 8'hE1, 0, 1'b0);
    a = 4'h7;
    b = 4'h9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_product", {24'd0, product}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrun_no_late_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(4'h3, 4'h5, 8'h0F, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
